// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI slave front end.
package spi_pkg;

   localparam int         SPI_DATA_W     = 8;
   localparam logic [7:0] SPI_DEFAULT_TX = 8'hFF;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } spi_state_e;

   // Bit-counter width; never narrower than one bit.
   function automatic int spi_cnt_w(input int data_w);
      return (data_w > 1) ? $clog2(data_w) : 1;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for a bundle of slow inputs plus rise/fall detect.
// All bits share one depth so their relative alignment is preserved.
module spi_sync_edge #(
   parameter int               WIDTH     = 3,
   parameter int               STAGES    = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             sysclk,
   input  logic             i_spi_rst_n,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_sync,
   output logic [WIDTH-1:0] o_rise,
   output logic [WIDTH-1:0] o_fall
);

   logic [WIDTH-1:0] r_stage [STAGES];
   logic [WIDTH-1:0] r_prev;

   always_ff @(posedge sysclk or negedge i_spi_rst_n) begin
      if (!i_spi_rst_n) begin
         for (int i = 0; i < STAGES; i++) r_stage[i] <= RESET_VAL;
         r_prev <= RESET_VAL;
      end else begin
         // NOTE: non-blocking so each stage takes its predecessor's old value.
         r_stage[0] <= i_async;
         for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
         r_prev <= r_stage[STAGES-1];
      end
   end

   assign o_sync = r_stage[STAGES-1];
   assign o_rise = o_sync & ~r_prev;
   assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/spi_slave_if.sv
// Mode-0 SPI slave: oversamples IOB-registered sclk/cs/mosi in the sysclk
// domain, deserialises MOSI words and shifts a one-entry TX holding register out on MISO.
module spi_slave_if
   import spi_pkg::*;
#(
   parameter int                DATA_W      = SPI_DATA_W,
   parameter int                SYNC_STAGES = 2,
   parameter logic [DATA_W-1:0] DEFAULT_TX  = DATA_W'(SPI_DEFAULT_TX)
) (
   input  logic              sysclk,
   input  logic              i_spi_rst_n,
   input  logic              i_sclk,
   input  logic              i_cs,
   input  logic              i_mosi,
   output logic              o_miso,
   output logic [DATA_W-1:0] o_rx_data,
   output logic              o_rx_valid,
   input  logic [DATA_W-1:0] i_tx_data,
   input  logic              i_tx_valid,
   output logic              o_tx_ready,
   output logic              o_tx_underrun,
   output logic              o_cs_active,
   output logic              o_frame_end
);

   localparam int               CNT_W    = spi_cnt_w(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   // Bit order of the synchronised bundle: {mosi, cs, sclk}; cs resets high (idle).
   logic [2:0] w_sync, w_rise, w_fall;
   logic       w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise, w_cs_sync, w_mosi;
   logic       w_unused_mosi_edges;

   spi_sync_edge #(
      .WIDTH     (3),
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (3'b010)
   ) u_sync (
      .sysclk      (sysclk),
      .i_spi_rst_n (i_spi_rst_n),
      .i_async     ({i_mosi, i_cs, i_sclk}),
      .o_sync      (w_sync),
      .o_rise      (w_rise),
      .o_fall      (w_fall)
   );

   assign w_sclk_rise         = w_rise[0];
   assign w_sclk_fall         = w_fall[0];
   assign w_cs_rise           = w_rise[1];
   assign w_cs_fall           = w_fall[1];
   assign w_cs_sync           = w_sync[1];
   assign w_mosi              = w_sync[2];
   assign w_unused_mosi_edges = ^{w_rise[2], w_fall[2]};

   spi_state_e        r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_bit_cnt;
   logic              r_load_pending;
   logic [DATA_W-2:0] r_rx_shift;
   logic [DATA_W-1:0] r_rx_data;
   logic              r_rx_valid;
   logic [DATA_W-1:0] r_tx_shift;
   logic [DATA_W-1:0] r_hold;
   logic              r_hold_full;
   logic              r_underrun;
   logic              r_frame_end;

   logic w_load, w_shift_tx, w_sample, w_word_done, w_frame_end, w_clr;

   always_ff @(posedge sysclk or negedge i_spi_rst_n) begin
      if (!i_spi_rst_n) r_state <= ST_IDLE;
      else              r_state <= w_state_nxt;
   end

   always_comb begin
      // NOTE: every signal gets a default first so no latch is inferred.
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_shift_tx  = 1'b0;
      w_sample    = 1'b0;
      w_word_done = 1'b0;
      w_frame_end = 1'b0;
      w_clr       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_cs_fall) begin
               w_state_nxt = ST_ACTIVE;
               w_load      = 1'b1;
               w_clr       = 1'b1;
            end
         end
         ST_ACTIVE: begin
            // A cs deassert masks any sclk edge seen in the same cycle.
            if (w_cs_rise) begin
               w_state_nxt = ST_IDLE;
               w_frame_end = 1'b1;
               w_clr       = 1'b1;
            end else begin
               if (w_sclk_rise) begin
                  w_sample    = 1'b1;
                  w_word_done = (r_bit_cnt == LAST_BIT);
               end
               if (w_sclk_fall) begin
                  w_load     = r_load_pending;
                  w_shift_tx = ~r_load_pending;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge sysclk or negedge i_spi_rst_n) begin
      if (!i_spi_rst_n) begin
         r_bit_cnt      <= '0;
         r_load_pending <= 1'b0;
         r_rx_shift     <= '0;
         r_rx_data      <= '0;
         r_rx_valid     <= 1'b0;
         r_tx_shift     <= '0;
         r_hold         <= '0;
         r_hold_full    <= 1'b0;
         r_underrun     <= 1'b0;
         r_frame_end    <= 1'b0;
      end else begin
         r_rx_valid  <= 1'b0;
         r_underrun  <= 1'b0;
         r_frame_end <= w_frame_end;

         if (w_clr) begin
            r_bit_cnt      <= '0;
            r_load_pending <= 1'b0;
         end

         if (w_sample) begin
            r_rx_shift <= (DATA_W-1)'({r_rx_shift, w_mosi});
            if (w_word_done) begin
               r_rx_data      <= {r_rx_shift, w_mosi};
               r_rx_valid     <= 1'b1;
               r_bit_cnt      <= '0;
               r_load_pending <= 1'b1;
            end else begin
               r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
         end

         if (w_shift_tx) r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};

         if (w_load) begin
            r_load_pending <= 1'b0;
            if (r_hold_full) begin
               r_tx_shift <= r_hold;
            end else begin
               r_tx_shift <= DEFAULT_TX;
               r_underrun <= 1'b1;
            end
         end

         // A load only consumes when full, and a write only lands when empty.
         if (w_load && r_hold_full) begin
            r_hold_full <= 1'b0;
         end else if (i_tx_valid && !r_hold_full) begin
            r_hold      <= i_tx_data;
            r_hold_full <= 1'b1;
         end
      end
   end

   assign o_miso        = (r_state == ST_ACTIVE) ? r_tx_shift[DATA_W-1] : 1'b0;
   assign o_rx_data     = r_rx_data;
   assign o_rx_valid    = r_rx_valid;
   assign o_tx_ready    = ~r_hold_full;
   assign o_tx_underrun = r_underrun;
   assign o_cs_active   = ~w_cs_sync;
   assign o_frame_end   = r_frame_end;

endmodule

// File: tb/tb_spi_slave_if.sv
// Scoreboard bench for spi_slave_if: a bus-functional SPI master drives frames,
// a TX-side model predicts MISO words and underruns, a monitor checks RX words.
`timescale 1ns/1ps
module tb_spi_slave_if;

   localparam logic [7:0] DEF_TX = 8'hFF;

   logic       sysclk = 1'b0;
   logic       i_spi_rst_n;
   logic       i_sclk, i_cs, i_mosi;
   logic       o_miso;
   logic [7:0] o_rx_data;
   logic       o_rx_valid;
   logic [7:0] i_tx_data;
   logic       i_tx_valid;
   logic       o_tx_ready, o_tx_underrun, o_cs_active, o_frame_end;

   always #20 sysclk = ~sysclk;

   spi_slave_if dut (
      .sysclk        (sysclk),
      .i_spi_rst_n   (i_spi_rst_n),
      .i_sclk        (i_sclk),
      .i_cs          (i_cs),
      .i_mosi        (i_mosi),
      .o_miso        (o_miso),
      .o_rx_data     (o_rx_data),
      .o_rx_valid    (o_rx_valid),
      .i_tx_data     (i_tx_data),
      .i_tx_valid    (i_tx_valid),
      .o_tx_ready    (o_tx_ready),
      .o_tx_underrun (o_tx_underrun),
      .o_cs_active   (o_cs_active),
      .o_frame_end   (o_frame_end)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model state: one-entry TX holding register plus event tallies.
   logic [7:0] m_hold;
   logic       m_full = 1'b0;
   int         m_underrun = 0, obs_underrun = 0;
   int         m_frame_end = 0, obs_frame_end = 0;
   logic [7:0] exp_rx[$];
   logic [7:0] mq[$];
   logic [8:0] tq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge sysclk);
   endtask

   task automatic model_load(output logic [7:0] val);
      if (m_full) begin
         val    = m_hold;
         m_full = 1'b0;
      end else begin
         val = DEF_TX;
         m_underrun++;
      end
   endtask

   task automatic tx_write(input logic [7:0] d);
      check("tx_ready", o_tx_ready, !m_full);
      i_tx_data  = d;
      i_tx_valid = 1'b1;
      if (!m_full) begin
         m_hold = d;
         m_full = 1'b1;
      end
      tick(1);
      i_tx_valid = 1'b0;
   endtask

   task automatic check_reset_outputs();
      check("rst_miso", o_miso, 0);
      check("rst_rx_data", o_rx_data, 0);
      check("rst_rx_valid", o_rx_valid, 0);
      check("rst_underrun", o_tx_underrun, 0);
      check("rst_cs_active", o_cs_active, 0);
      check("rst_frame_end", o_frame_end, 0);
      check("rst_tx_ready", o_tx_ready, 1);
   endtask

   // One frame: full words from mq, then 'partial' extra bits; tq[w] (bit 8 = enable)
   // is written to TX during word w. cs is raised while sclk is still high.
   task automatic run_frame(input int partial);
      logic [7:0] cur_tx, got;
      int nw, nbits, w, k;
      nw     = mq.size();
      nbits  = nw * 8 + partial;
      got    = '0;
      i_cs   = 1'b0;
      model_load(cur_tx);
      for (int b = 0; b < nbits; b++) begin
         w = b / 8;
         k = b % 8;
         i_mosi = (w < nw) ? mq[w][7-k] : 1'($urandom);
         tick(4);
         if (b == 0) begin
            check("cs_active", o_cs_active, 1);
            check("tx_ready_after_load", o_tx_ready, !m_full);
         end
         got[7-k] = o_miso;
         i_sclk   = 1'b1;
         if (k == 7 && w < nw) exp_rx.push_back(mq[w]);
         if (k == 0 && w < tq.size() && tq[w][8]) begin
            tx_write(tq[w][7:0]);
            tick(3);
         end else begin
            tick(4);
         end
         if (k == 7 && w < nw) check("miso_word", got, cur_tx);
         if (b != nbits - 1) begin
            i_sclk = 1'b0;
            if (k == 7) model_load(cur_tx);
         end
      end
      i_cs = 1'b1;
      m_frame_end++;
      tick(4);
      i_sclk = 1'b0;
      tick(10);
      check("frame_end_count", obs_frame_end, m_frame_end);
      check("underrun_count", obs_underrun, m_underrun);
      check("rx_all_received", exp_rx.size(), 0);
      check("idle_cs_active", o_cs_active, 0);
      check("idle_miso", o_miso, 0);
   endtask

   // Monitor: pops the scoreboard on every RX pulse and tallies 1-cycle pulses.
   always @(negedge sysclk) begin
      if (i_spi_rst_n === 1'b1) begin
         if (o_rx_valid) begin
            check("rx_expected", exp_rx.size() != 0, 1);
            if (exp_rx.size() != 0) check("rx_data", o_rx_data, exp_rx.pop_front());
         end
         if (o_tx_underrun) obs_underrun++;
         if (o_frame_end) obs_frame_end++;
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      i_spi_rst_n = 1'b0;
      i_sclk      = 1'b0;
      i_cs        = 1'b1;
      i_mosi      = 1'b0;
      i_tx_data   = '0;
      i_tx_valid  = 1'b0;
      tick(3);
      check_reset_outputs();
      i_spi_rst_n = 1'b1;
      tick(4);

      // Single word with a preloaded TX word.
      tx_write(8'hA5);
      mq = {8'h3C}; tq = {};
      run_frame(0);

      // Back-to-back words, TX refilled on each ready.
      tx_write(8'h11);
      mq = {8'h01, 8'h80, 8'hFF}; tq = {9'h122, 9'h133};
      run_frame(0);

      // TX left empty: two underruns.
      mq = {8'h12, 8'h34}; tq = {};
      run_frame(0);

      // Abort after 5 bits, then a clean frame.
      mq = {}; tq = {};
      run_frame(5);
      mq = {8'hC3};
      run_frame(0);

      // Reset in the middle of a word.
      i_cs = 1'b0;
      tick(4);
      for (int b = 0; b < 3; b++) begin
         i_mosi = 1'($urandom);
         tick(4);
         i_sclk = 1'b1;
         tick(4);
         i_sclk = 1'b0;
      end
      tick(2);
      i_spi_rst_n = 1'b0;
      tick(1);
      check_reset_outputs();
      i_cs   = 1'b1;
      i_sclk = 1'b0;
      tick(2);
      check_reset_outputs();
      m_full = 1'b0; m_underrun = 0; obs_underrun = 0;
      m_frame_end = 0; obs_frame_end = 0;
      exp_rx.delete();
      i_spi_rst_n = 1'b1;
      tick(4);
      mq = {8'h5A}; tq = {};
      run_frame(0);

      // Write while full is ignored; the held word goes out.
      tx_write(8'h77);
      tick(2);
      tx_write(8'hEE);
      mq = {8'h96}; tq = {};
      run_frame(0);

      // Randomised frames.
      for (int f = 0; f < 24; f++) begin
         int nw, part;
         nw   = $urandom_range(1, 3);
         part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
         mq = {}; tq = {};
         for (int i = 0; i < nw; i++) begin
            mq.push_back(8'($urandom));
            tq.push_back({1'($urandom), 8'($urandom)});
         end
         if ($urandom_range(0, 1) == 1) tx_write(8'($urandom));
         run_frame(part);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
